// File: rtl/seg_display_scheduler.sv
// Display source scheduler for a 4-digit BCD seven-segment display.
// Arbitrates between a BCD game timer, a serially converted mine count and a timed message overlay.
module seg_display_scheduler #(
    parameter int unsigned TICK_DIV        = 100_000_000,
    parameter int unsigned MSG_HOLD_CYCLES = 200_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_run_i,
    input  logic        timer_clr_i,
    input  logic [7:0]  mine_left_i,
    input  logic        view_toggle_i,
    input  logic        msg_req_i,
    input  logic [15:0] msg_code_i,
    output logic [15:0] seg_8421_code_o,
    output logic        view_o,
    output logic        msg_active_o,
    output logic        conv_busy_o
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = (MSG_HOLD_CYCLES > 1) ? $clog2(MSG_HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        VIEW_TIMER = 2'd0,
        VIEW_MINES = 2'd1,
        MSG        = 2'd2
    } state_t;

    state_t      state;
    logic [PW-1:0] presc;
    logic [15:0] timer_bcd;
    logic [7:0]  mine_latched;
    logic [7:0]  bin_sh;
    logic [11:0] scratch;
    logic [11:0] mine_bcd;
    logic [2:0]  iter;
    logic [15:0] msg_code;
    logic [HW-1:0] hold;
    logic        view_next;
    logic [11:0] adj;
    logic [11:0] scratch_next;

    // Decimal ripple increment of a packed 4-digit BCD value.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Game timer: prescaler plus saturating BCD seconds count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            timer_bcd <= '0;
        end else if (timer_clr_i) begin
            presc     <= '0;
            timer_bcd <= '0;
        end else if (timer_run_i) begin
            if (presc == PW'(TICK_DIV - 1)) begin
                presc <= '0;
                if (timer_bcd != 16'h9999) begin
                    timer_bcd <= bcd_inc(timer_bcd);
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // One double-dabble step: add-3 correction then shift in the next binary bit.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_next = {adj[10:0], bin_sh[7]};
    end

    // Serial binary-to-BCD engine; new input only considered while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mine_latched <= '0;
            bin_sh       <= '0;
            scratch      <= '0;
            mine_bcd     <= '0;
            iter         <= '0;
            conv_busy_o  <= 1'b0;
        end else if (!conv_busy_o) begin
            if (mine_left_i != mine_latched) begin
                mine_latched <= mine_left_i;
                bin_sh       <= mine_left_i;
                scratch      <= '0;
                iter         <= '0;
                conv_busy_o  <= 1'b1;
            end
        end else begin
            scratch <= scratch_next;
            bin_sh  <= {bin_sh[6:0], 1'b0};
            iter    <= iter + 3'd1;
            if (iter == 3'd7) begin
                mine_bcd    <= scratch_next;
                conv_busy_o <= 1'b0;
            end
        end
    end

    assign view_next = view_o ^ view_toggle_i;

    // View/message state machine with registered display mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= VIEW_TIMER;
            view_o          <= 1'b0;
            msg_active_o    <= 1'b0;
            msg_code        <= '0;
            hold            <= '0;
            seg_8421_code_o <= '0;
        end else begin
            view_o <= view_next;
            if (msg_req_i) begin
                msg_code     <= msg_code_i;
                hold         <= HW'(MSG_HOLD_CYCLES - 1);
                state        <= MSG;
                msg_active_o <= 1'b1;
            end else if (state == MSG) begin
                if (hold == '0) begin
                    state        <= view_next ? VIEW_MINES : VIEW_TIMER;
                    msg_active_o <= 1'b0;
                end else begin
                    hold <= hold - HW'(1);
                end
            end else begin
                state <= view_next ? VIEW_MINES : VIEW_TIMER;
            end

            case (state)
                MSG:        seg_8421_code_o <= msg_code;
                VIEW_MINES: seg_8421_code_o <= {4'h0, mine_bcd};
                default:    seg_8421_code_o <= timer_bcd;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_display_scheduler.sv
// Randomized scoreboard bench for seg_display_scheduler against an arithmetic reference model.
module tb_seg_display_scheduler;
    localparam int unsigned TD = 4;
    localparam int unsigned MH = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        timer_run_i = 1'b0;
    logic        timer_clr_i = 1'b0;
    logic [7:0]  mine_left_i = '0;
    logic        view_toggle_i = 1'b0;
    logic        msg_req_i = 1'b0;
    logic [15:0] msg_code_i = '0;
    logic [15:0] seg_8421_code_o;
    logic        view_o;
    logic        msg_active_o;
    logic        conv_busy_o;

    seg_display_scheduler #(.TICK_DIV(TD), .MSG_HOLD_CYCLES(MH)) dut (
        .clk(clk), .rst(rst),
        .timer_run_i(timer_run_i), .timer_clr_i(timer_clr_i),
        .mine_left_i(mine_left_i), .view_toggle_i(view_toggle_i),
        .msg_req_i(msg_req_i), .msg_code_i(msg_code_i),
        .seg_8421_code_o(seg_8421_code_o), .view_o(view_o),
        .msg_active_o(msg_active_o), .conv_busy_o(conv_busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] seg;
        logic        view;
        logic        act;
        logic        busy;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state, kept as plain integers.
    int m_timer, m_presc, m_latch, m_conv_left, m_mine, m_hold;
    bit m_view, m_act;
    logic [15:0] m_code;

    function automatic logic [15:0] to_bcd4(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_timer = 0; m_presc = 0; m_latch = 0; m_conv_left = 0; m_mine = 0; m_hold = 0;
        m_view = 1'b0; m_act = 1'b0; m_code = '0;
    endtask

    // Advance the model across one clock edge and return what the outputs show afterwards.
    task automatic model_step(output obs_t o);
        logic [15:0] seg;
        if (m_act)       seg = m_code;
        else if (m_view) seg = to_bcd4(m_mine);
        else             seg = to_bcd4(m_timer);

        if (timer_clr_i) begin
            m_timer = 0; m_presc = 0;
        end else if (timer_run_i) begin
            if (m_presc == int'(TD) - 1) begin
                m_presc = 0;
                if (m_timer < 9999) m_timer++;
            end else m_presc++;
        end

        if (m_conv_left == 0) begin
            if (int'(mine_left_i) != m_latch) begin
                m_latch = int'(mine_left_i);
                m_conv_left = 8;
            end
        end else begin
            m_conv_left--;
            if (m_conv_left == 0) m_mine = m_latch;
        end

        if (view_toggle_i) m_view = !m_view;
        if (msg_req_i) begin
            m_code = msg_code_i; m_hold = int'(MH) - 1; m_act = 1'b1;
        end else if (m_act) begin
            if (m_hold == 0) m_act = 1'b0;
            else m_hold--;
        end

        o = '{seg: seg, view: m_view, act: m_act, busy: (m_conv_left != 0)};
    endtask

    task automatic step(input bit run, input bit clr, input logic [7:0] mine,
                        input bit tog, input bit req, input logic [15:0] code);
        obs_t e;
        @(negedge clk);
        rst = 1'b0;
        timer_run_i = run; timer_clr_i = clr; mine_left_i = mine;
        view_toggle_i = tog; msg_req_i = req; msg_code_i = code;
        model_step(e);
        q.push_back(e);
    endtask

    task automatic idle(input int n, input bit run, input logic [7:0] mine);
        for (int i = 0; i < n; i++) step(run, 1'b0, mine, 1'b0, 1'b0, 16'h0000);
    endtask

    // Assert reset between edges and expect every output to drop without a clock.
    task automatic async_reset();
        obs_t got;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        got = {seg_8421_code_o, view_o, msg_active_o, conv_busy_o};
        checks++;
        if (got !== obs_t'(0)) begin
            failures++;
            $display("FAIL async_reset got=%h required=0", got);
        end
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            q.push_back('0);
        end
    endtask

    // Monitor: outputs are valid every cycle, compare against the oldest expectation.
    initial begin
        obs_t exp_o, got;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_o = q.pop_front();
                got = {seg_8421_code_o, view_o, msg_active_o, conv_busy_o};
                checks++;
                if (got !== exp_o) begin
                    failures++;
                    $display("FAIL outputs t=%0t got seg=%h view=%b act=%b busy=%b required seg=%h view=%b act=%b busy=%b",
                             $time, got.seg, got.view, got.act, got.busy,
                             exp_o.seg, exp_o.view, exp_o.act, exp_o.busy);
                end
            end
        end
    end

    initial begin
        logic [7:0]  rmine;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            q.push_back('0);
        end

        // Timer counting, freeze, clear.
        idle(45, 1'b1, 8'd0);
        idle(6, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 16'h0);
        idle(3, 1'b1, 8'd0);

        // Mine conversions in mines view, including change mid-conversion.
        step(1'b0, 1'b0, 8'd237, 1'b1, 1'b0, 16'h0);
        idle(12, 1'b0, 8'd237);
        idle(12, 1'b0, 8'd0);
        idle(12, 1'b0, 8'd255);
        idle(3, 1'b0, 8'd100);
        idle(20, 1'b0, 8'd57);

        // Message overlay, toggle during message, renewal, reset mid-message.
        step(1'b0, 1'b0, 8'd57, 1'b0, 1'b1, 16'hDEAD);
        idle(8, 1'b0, 8'd57);
        step(1'b0, 1'b0, 8'd57, 1'b0, 1'b1, 16'hDEAD);
        step(1'b0, 1'b0, 8'd57, 1'b1, 1'b0, 16'h0);
        idle(8, 1'b0, 8'd57);
        step(1'b0, 1'b0, 8'd57, 1'b1, 1'b1, 16'hDEAD);
        idle(2, 1'b0, 8'd57);
        step(1'b0, 1'b0, 8'd57, 1'b0, 1'b1, 16'hBEEF);
        idle(8, 1'b0, 8'd57);
        step(1'b0, 1'b0, 8'd57, 1'b0, 1'b1, 16'h1234);
        idle(2, 1'b0, 8'd57);
        async_reset();
        idle(12, 1'b0, 8'd57);

        // Randomized mix of all inputs.
        rmine = 8'd57;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) rmine = 8'($urandom);
            step(($urandom_range(7) != 0), ($urandom_range(63) == 0), rmine,
                 ($urandom_range(15) == 0), ($urandom_range(31) == 0), 16'($urandom));
        end

        // Run to saturation in timer view and hold past 9999.
        async_reset();
        idle(10000 * int'(TD) + 20, 1'b1, 8'd0);

        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Sequential controller that decides what the 4-digit seven-segment display shows and drives the 16-bit packed BCD word consumed by the display path (4 digits × 4 bits, digit 3 in [15:12]). Shares the display between three sources: an internal BCD game timer, the remaining-mine count (converted on the fly by a serial binary-to-BCD engine) and a transient message overlay with timed hold. Sits between game logic and the IO processing top; its view-toggle input is a debounced one-cycle button pulse.

## Interface
Parameters:
- TICK_DIV, 100_000_000: clock cycles per timer second (≥2).
- MSG_HOLD_CYCLES, 200_000_000: cycles a message stays on display (≥1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- timer_run_i  in  1  level; timer counts while high.
- timer_clr_i  in  1  pulse/level; clears timer and prescaler; priority over run.
- mine_left_i  in  8  remaining mines, binary 0..255.
- view_toggle_i  in  1  one-cycle pulse; flips base view timer↔mines.
- msg_req_i  in  1  one-cycle pulse; show msg_code_i as overlay.
- msg_code_i  in  16  packed 4-digit code, sampled when msg_req_i high.
- seg_8421_code_o  out  16  registered display word.
- view_o  out  1  base view: 0 timer, 1 mines.
- msg_active_o  out  1  overlay currently shown.
- conv_busy_o  out  1  binary-to-BCD engine running.

## Operation
- Reset values: seg_8421_code_o=16'h0000, view_o=0, msg_active_o=0, conv_busy_o=0; timer count, prescaler, mine BCD result, latched mine value, message code and hold counter all 0; state VIEW_TIMER.
- Timer: prescaler counts 0..TICK_DIV-1 while timer_run_i; on the wrap cycle the 4-digit BCD count increments with decimal ripple (0009→0010, 0999→1000). Saturates at 9999 (prescaler keeps running, count holds). timer_run_i low freezes prescaler and count. timer_clr_i zeroes both same edge, regardless of run.
- Mine conversion (double-dabble): when idle and mine_left_i ≠ latched value, latch mine_left_i, clear scratch, set conv_busy_o. Then 8 iterations, one per cycle: add 3 to any BCD nibble ≥5, shift left one bit. On the 8th iteration's edge write 12-bit result to mine BCD register, clear busy. Input changes during conversion are ignored; compared again once idle. Mine view word = {4'h0, hundreds, tens, ones}.
- States: VIEW_TIMER, VIEW_MINES, MSG (base view tracked separately in view_o).
  - view_toggle_i flips view_o in any state; in VIEW_* state moves to matching view immediately.
  - msg_req_i in any state: latch msg_code_i, load hold counter MSG_HOLD_CYCLES-1, enter MSG. Request during MSG reloads code and restarts hold.
  - MSG: counter decrements each cycle; on cycle where counter=0 and no new request, return to view given by view_o.
  - msg_req_i and view_toggle_i same cycle: both take effect.
- Output mux registered: seg_8421_code_o = msg code in MSG, else timer or mine word per state.

## Timing
- All outputs registered; any input/event visible on outputs exactly 1 cycle after the sampling edge.
- Timer: run high from cycle 0 (after reset) → count=0001 internally after TICK_DIV edges; seg output shows it 1 cycle later when in timer view.
- Conversion latency: change sampled at edge n → busy high from n+1, result registered at edge n+9, on seg output at n+10 (mines view). busy high exactly 8 cycles.
- msg_active_o high exactly MSG_HOLD_CYCLES cycles per unrenewed request.
- Reset mid-conversion or mid-message aborts immediately to reset values; after release, nonzero mine_left_i starts conversion on first clock.

## Test plan
- TICK_DIV=4, run high 40 cycles from reset, timer view → seg goes 0000, 0001 … 0010; run low freezes; clr pulse → 0000 next cycle.
- Preload count 9998 via run, two more ticks → 9999 and stays 9999.
- mine_left_i=8'd237, toggle to mines view → conv_busy_o high 8 cycles, seg=16'h0237 at cycle 10 after change; 0→16'h0000, 255→16'h0255.
- Change mine_left_i 100→57 mid-conversion → first shows 0100, then 0057 after second conversion.
- MSG_HOLD_CYCLES=5, msg_req with 16'hDEAD in mines view → seg=DEAD, msg_active_o high 5 cycles, then seg returns to mine word; toggle during MSG → returns to timer view.
- Re-request at hold cycle 3 with 16'hBEEF → BEEF shown, hold restarts (active 3+5 cycles total); assert rst mid-message → all outputs 0 asynchronously.
